// File: rtl/mcpu_exec_ctrl.sv
// Multi-cycle execute-stage controller: owns the register file and sequences one
// ALU instruction at a time through READ / WAIT (ALU settle) / WB.
module mcpu_exec_ctrl #(
    parameter int CMD_SIZE      = 3,
    parameter int WORD_SIZE     = 16,
    parameter int REG_ADDR      = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [CMD_SIZE-1:0]  instr_cmd,
    input  logic [REG_ADDR-1:0]  instr_rd,
    input  logic [REG_ADDR-1:0]  instr_rs1,
    input  logic [REG_ADDR-1:0]  instr_rs2,
    input  logic                 ext_wr_en,
    input  logic [REG_ADDR-1:0]  ext_wr_addr,
    input  logic [WORD_SIZE-1:0] ext_wr_data,
    output logic [CMD_SIZE-1:0]  alu_cmd,
    output logic [WORD_SIZE-1:0] alu_in1,
    output logic [WORD_SIZE-1:0] alu_in2,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_cf,
    output logic                 done,
    output logic                 cf_flag,
    input  logic [REG_ADDR-1:0]  dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data,
    output logic [1:0]           dbg_state
);

    // Handshake: an instruction is accepted on a rising edge where
    // instr_valid && instr_ready; valid may drop without acceptance.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam int NREGS = 1 << REG_ADDR;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           settle_cnt;
    logic [CMD_SIZE-1:0]  lat_cmd;
    logic [REG_ADDR-1:0]  lat_rd;
    logic [REG_ADDR-1:0]  lat_rs1;
    logic [REG_ADDR-1:0]  lat_rs2;
    logic [WORD_SIZE-1:0] regs [NREGS];
    logic                 accept;
    logic                 add_class;

    assign accept    = instr_valid && instr_ready;
    // Commands 6 and 7 execute as ADD inside the ALU, so they update carry too.
    assign add_class = (lat_cmd == CMD_SIZE'(3)) || (lat_cmd == CMD_SIZE'(6)) ||
                       (lat_cmd == CMD_SIZE'(7));
    assign dbg_data  = regs[dbg_addr];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_READ;
            S_READ: state_nxt = S_WAIT;
            S_WAIT: if (settle_cnt == 4'd0) state_nxt = S_WB;
            S_WB:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        dbg_state   = state;
        case (state)
            S_IDLE: instr_ready = !reset;
            S_WB:   done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latches, ALU drive, settle counter, register file, carry flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            lat_cmd    <= '0;
            lat_rd     <= '0;
            lat_rs1    <= '0;
            lat_rs2    <= '0;
            alu_cmd    <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            cf_flag    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (ext_wr_en) begin
                        regs[ext_wr_addr] <= ext_wr_data;
                    end
                    if (accept) begin
                        lat_cmd <= instr_cmd;
                        lat_rd  <= instr_rd;
                        lat_rs1 <= instr_rs1;
                        lat_rs2 <= instr_rs2;
                    end
                end
                S_READ: begin
                    // Sources captured here, so rd == rs1/rs2 is harmless at WB.
                    alu_cmd    <= lat_cmd;
                    alu_in1    <= regs[lat_rs1];
                    alu_in2    <= regs[lat_rs2];
                    settle_cnt <= SETTLE_LOAD;
                end
                S_WAIT: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_WB: begin
                    regs[lat_rd] <= alu_out;
                    if (add_class) begin
                        cf_flag <= alu_cf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_exec_ctrl.sv
// Directed bench for mcpu_exec_ctrl: default-settle instance for function checks,
// SETTLE_CYCLES=3 instance for back-to-back occupancy.
module tb_mcpu_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_cmd;
    logic [1:0]  instr_rd, instr_rs1, instr_rs2;
    logic        ext_wr_en;
    logic [1:0]  ext_wr_addr;
    logic [15:0] ext_wr_data;
    logic [2:0]  alu_cmd;
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic        alu_cf;
    logic        done, cf_flag;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [1:0]  dbg_state;

    logic        s3_valid, s3_ready;
    logic [2:0]  s3_cmd;
    logic [1:0]  s3_rd, s3_rs1, s3_rs2;
    logic        s3_ext_en;
    logic [1:0]  s3_ext_addr;
    logic [15:0] s3_ext_data;
    logic [2:0]  s3_alu_cmd;
    logic [15:0] s3_alu_in1, s3_alu_in2, s3_alu_out;
    logic        s3_alu_cf;
    logic        s3_done, s3_cf_flag;
    logic [1:0]  s3_dbg_addr;
    logic [15:0] s3_dbg_data;
    logic [1:0]  s3_dbg_state;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    always #5 clk = ~clk;

    mcpu_exec_ctrl u_dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_cmd(instr_cmd), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .alu_cmd(alu_cmd), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_cf(alu_cf),
        .done(done), .cf_flag(cf_flag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    mcpu_exec_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .instr_valid(s3_valid), .instr_ready(s3_ready),
        .instr_cmd(s3_cmd), .instr_rd(s3_rd),
        .instr_rs1(s3_rs1), .instr_rs2(s3_rs2),
        .ext_wr_en(s3_ext_en), .ext_wr_addr(s3_ext_addr), .ext_wr_data(s3_ext_data),
        .alu_cmd(s3_alu_cmd), .alu_in1(s3_alu_in1), .alu_in2(s3_alu_in2),
        .alu_out(s3_alu_out), .alu_cf(s3_alu_cf),
        .done(s3_done), .cf_flag(s3_cf_flag),
        .dbg_addr(s3_dbg_addr), .dbg_data(s3_dbg_data), .dbg_state(s3_dbg_state)
    );

    // Behavioural stand-in for the downstream combinational ALU.
    function automatic logic [16:0] alu_model(input logic [2:0] c, input logic [15:0] a,
                                              input logic [15:0] b);
        case (c)
            3'd0: alu_model = {1'b0, a & b};
            3'd1: alu_model = {1'b0, a | b};
            3'd2: alu_model = {1'b0, a ^ b};
            3'd4: alu_model = (b >= 16'd16) ? 17'd0 : {1'b0, a << b[3:0]};
            3'd5: alu_model = (b >= 16'd16) ? 17'd0 : {1'b0, a >> b[3:0]};
            default: alu_model = {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    always_comb {alu_cf, alu_out} = alu_model(alu_cmd, alu_in1, alu_in2);
    always_comb {s3_alu_cf, s3_alu_out} = alu_model(s3_alu_cmd, s3_alu_in1, s3_alu_in2);

    always @(posedge clk) if (done) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ext_write(input logic [1:0] addr, input logic [15:0] data);
        ext_wr_en   = 1'b1;
        ext_wr_addr = addr;
        ext_wr_data = data;
        tick();
        ext_wr_en = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Accept one instruction, return cycles from accept to done (accept cycle = 0),
    // and leave the controller back in IDLE.
    task automatic run_instr(input logic [2:0] cmd, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, output int lat);
        instr_valid = 1'b1;
        instr_cmd   = cmd;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        tick();
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        if (lat >= 30) check("done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        int lat;
        int first_acc, second_acc, low_cnt;
        reset = 1'b1;
        instr_valid = 1'b0; instr_cmd = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
        ext_wr_en = 1'b0; ext_wr_addr = '0; ext_wr_data = '0; dbg_addr = '0;
        s3_valid = 1'b0; s3_cmd = '0; s3_rd = '0; s3_rs1 = '0; s3_rs2 = '0;
        s3_ext_en = 1'b0; s3_ext_addr = '0; s3_ext_data = '0; s3_dbg_addr = '0;

        // Reset state
        tick(); tick(); tick();
        check("ready_in_reset", instr_ready, 1'b0);
        check("state_in_reset", dbg_state, ST_IDLE);
        check("cf_in_reset", cf_flag, 1'b0);
        check("done_in_reset", done, 1'b0);
        check("alu_in1_in_reset", alu_in1, 16'h0000);
        reset = 1'b0;
        tick();
        check("ready_after_reset", instr_ready, 1'b1);
        for (int i = 0; i < 4; i++) check_reg($sformatf("reg%0d_reset", i), 2'(i), 16'h0000);

        // ADD with carry out, latency of done, then AND keeps carry
        ext_write(2'd1, 16'hFFFF);
        ext_write(2'd2, 16'h0001);
        run_instr(3'd3, 2'd3, 2'd1, 2'd2, lat);
        check("add_done_latency", lat, 3);
        check("done_one_cycle", done, 1'b0);
        check("ready_after_wb", instr_ready, 1'b1);
        check_reg("add_result", 2'd3, 16'h0000);
        check("add_cf", cf_flag, 1'b1);
        check("alu_cmd_held", alu_cmd, 3'd3);
        check("alu_in1_held", alu_in1, 16'hFFFF);
        run_instr(3'd0, 2'd0, 2'd1, 2'd2, lat);
        check_reg("and_result", 2'd0, 16'h0001);
        check("and_keeps_cf", cf_flag, 1'b1);

        // Shifts, rd == rs1, and shift amount >= WORD_SIZE
        ext_write(2'd1, 16'h00F0);
        ext_write(2'd2, 16'h0004);
        run_instr(3'd4, 2'd1, 2'd1, 2'd2, lat);
        check_reg("lsl_rd_eq_rs1", 2'd1, 16'h0F00);
        ext_write(2'd2, 16'h0010);
        run_instr(3'd5, 2'd0, 2'd1, 2'd2, lat);
        check_reg("lsr_by_16", 2'd0, 16'h0000);
        check("shift_keeps_cf", cf_flag, 1'b1);

        // Same-cycle external write and accept; write during WAIT ignored
        ext_write(2'd0, 16'h5555);
        ext_wr_en = 1'b1; ext_wr_addr = 2'd2; ext_wr_data = 16'h1234;
        instr_valid = 1'b1; instr_cmd = 3'd2; instr_rd = 2'd0; instr_rs1 = 2'd2; instr_rs2 = 2'd2;
        tick();
        ext_wr_en = 1'b0; instr_valid = 1'b0;
        check("xor_state_read", dbg_state, ST_READ);
        tick();
        check("xor_state_wait", dbg_state, ST_WAIT);
        check("xor_alu_in1_wait", alu_in1, 16'h1234);
        check("xor_alu_in2_wait", alu_in2, 16'h1234);
        ext_wr_en = 1'b1; ext_wr_addr = 2'd1; ext_wr_data = 16'hBEEF;
        tick();
        ext_wr_en = 1'b0;
        check("xor_done", done, 1'b1);
        tick();
        check_reg("xor_result", 2'd0, 16'h0000);
        check_reg("ext_write_in_wait_ignored", 2'd1, 16'h0F00);
        check_reg("ext_write_same_cycle", 2'd2, 16'h1234);

        // Reset during WAIT abandons the instruction
        instr_valid = 1'b1; instr_cmd = 3'd3; instr_rd = 2'd2; instr_rs1 = 2'd1; instr_rs2 = 2'd1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("pre_reset_state_wait", dbg_state, ST_WAIT);
        lat = done_cnt;
        reset = 1'b1;
        tick();
        check("mid_reset_state", dbg_state, ST_IDLE);
        check("mid_reset_ready", instr_ready, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        check("no_done_after_reset", done_cnt, lat);
        check_reg("no_wb_after_reset", 2'd2, 16'h0000);
        check("cf_cleared", cf_flag, 1'b0);
        check("alu_in1_cleared", alu_in1, 16'h0000);
        ext_write(2'd1, 16'h8001);
        ext_write(2'd3, 16'h8000);
        run_instr(3'd7, 2'd2, 2'd1, 2'd3, lat);
        check("post_reset_latency", lat, 3);
        check_reg("post_reset_add", 2'd2, 16'h0001);
        check("post_reset_cf", cf_flag, 1'b1);

        // SETTLE_CYCLES=3: back-to-back valid, measure accept spacing
        s3_valid = 1'b1; s3_cmd = 3'd3; s3_rd = 2'd0; s3_rs1 = 2'd0; s3_rs2 = 2'd0;
        first_acc = -1; second_acc = -1; low_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (s3_ready) begin
                if (first_acc < 0) first_acc = c;
                else if (second_acc < 0) second_acc = c;
            end else if (first_acc >= 0 && second_acc < 0) begin
                low_cnt++;
            end
            tick();
        end
        s3_valid = 1'b0;
        check("s3_first_accept_seen", (first_acc >= 0), 1'b1);
        check("s3_accept_to_accept", second_acc - first_acc, 6);
        check("s3_ready_low_cycles", low_cnt, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
